// File: rtl/lfsr_scrambler_pkg.sv
// lfsr_pkg: shared constants and the Galois LFSR step function for the
// serial scrambler. The step function works on a wide word so one definition
// serves every LFSR width up to LFSR_MAX_W; callers cast the result back down.
package lfsr_pkg;

  localparam int          LFSR_WIDTH_DEFAULT = 8;
  localparam logic [7:0]  TAPS_DEFAULT       = 8'hB8;
  localparam logic [7:0]  SEED_DEFAULT       = 8'h01;

  localparam int LFSR_MAX_W = 64;
  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  // Galois step: shift right, fold the taps in when the bit leaving is 1.
  // With zero-extended inputs the upper bits stay zero.
  function automatic lfsr_word_t lfsr_step(lfsr_word_t state, lfsr_word_t taps);
    return (state >> 1) ^ (state[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/lfsr_scrambler_if.sv
// lfsr_scrambler_if: seed-load and valid/ready bit-stream handshake bundle.
//   master : seed_load, seed, in_valid, in_bit, out_ready (driven by the user)
//   slave  : in_ready, out_valid, out_bit, out_last      (driven by the block)
interface lfsr_scrambler_if #(
  parameter int WIDTH = 8
);
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_last;

  modport master (
    output seed_load, seed, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  seed_load, seed, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/lfsr_scrambler_core.sv
// lfsr_core: the Galois LFSR register.
//   clk, rst   : clock, synchronous active-high reset (state <= SEED)
//   load       : replace state with load_value (wins over advance)
//   load_value : value loaded on load
//   advance    : step the LFSR once
//   state      : current LFSR contents; state[0] is the key bit
module lfsr_core import lfsr_pkg::*; #(
  parameter int               WIDTH = LFSR_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_DEFAULT),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = load_value;
    else if (advance)
      state_d = WIDTH'(lfsr_step(lfsr_word_t'(state_q), lfsr_word_t'(TAPS)));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_scrambler.sv
// lfsr_scrambler: XORs a Galois LFSR keystream onto a serial bit stream.
// The keystream restarts from the stored seed every FRAME_LEN bits, so an
// identically seeded instance on the far side descrambles the stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of lfsr_scrambler_if (seed load, in/out handshakes)
// One registered output stage; a new bit is accepted whenever that stage is
// empty or draining this cycle, and never during a seed load.
module lfsr_scrambler import lfsr_pkg::*; #(
  parameter int               WIDTH     = LFSR_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_DEFAULT),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(SEED_DEFAULT),
  parameter int               FRAME_LEN = 16
) (
  input logic              clk,
  input logic              rst,
  lfsr_scrambler_if.slave  bus
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic             out_last_q, out_last_d;

  logic             in_ready, in_xfer, frame_end;
  logic [WIDTH-1:0] seed_coerced;
  logic             core_load, core_adv;
  logic [WIDTH-1:0] core_value, lfsr_state;

  always_comb begin
    in_ready     = (!out_valid_q || bus.out_ready) && !bus.seed_load;
    in_xfer      = bus.in_valid && in_ready;
    frame_end    = (frame_cnt_q == CNT_LAST);
    // An all-zero Galois LFSR never leaves zero, so a zero seed becomes 1.
    seed_coerced = (bus.seed == '0) ? WIDTH'(1) : bus.seed;

    // The last bit of a frame reloads the seed instead of stepping.
    core_load  = bus.seed_load || (in_xfer && frame_end);
    core_value = bus.seed_load ? seed_coerced : seed_reg_q;
    core_adv   = in_xfer && !frame_end;

    seed_reg_d = bus.seed_load ? seed_coerced : seed_reg_q;

    frame_cnt_d = frame_cnt_q;
    if (bus.seed_load)
      frame_cnt_d = '0;
    else if (in_xfer)
      frame_cnt_d = frame_end ? '0 : frame_cnt_q + CNT_W'(1);

    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_last_d  = out_last_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_bit_d   = bus.in_bit ^ lfsr_state[0];
      out_last_d  = frame_end;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_reg_q  <= SEED;
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      seed_reg_q  <= seed_reg_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (core_load),
    .load_value (core_value),
    .advance    (core_adv),
    .state      (lfsr_state)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_lfsr_scrambler.sv
module tb_lfsr_scrambler;
  localparam int         W    = 8;
  localparam int         FL   = 16;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tb_in_valid = 1'b0, tb_in_bit = 1'b0, tb_out_ready = 1'b1;
  logic       tb_seed_load = 1'b0, tb_b_seed_load = 1'b0, tb_b_ready = 1'b1;
  logic [7:0] tb_seed = 8'h00;
  logic       lb = 1'b0;

  lfsr_scrambler_if #(.WIDTH(W)) a ();
  lfsr_scrambler_if #(.WIDTH(W)) b ();

  assign a.in_valid  = tb_in_valid;
  assign a.in_bit    = tb_in_bit;
  assign a.seed_load = tb_seed_load;
  assign a.seed      = tb_seed;
  assign a.out_ready = lb ? b.in_ready : tb_out_ready;
  assign b.in_valid  = lb ? a.out_valid : 1'b0;
  assign b.in_bit    = a.out_bit;
  assign b.seed_load = tb_b_seed_load;
  assign b.seed      = tb_seed;
  assign b.out_ready = tb_b_ready;

  lfsr_scrambler #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .FRAME_LEN(FL)) u_scr (
    .clk(clk), .rst(rst), .bus(a));
  lfsr_scrambler #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .FRAME_LEN(FL)) u_dsc (
    .clk(clk), .rst(rst), .bus(b));

  int vectors = 0, miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Key bit n positions into a frame started from seed s.
  function automatic logic keybit(logic [7:0] s, int n);
    for (int i = 0; i < n; i++) s = (s >> 1) ^ (s[0] ? TAPS : 8'h00);
    return s[0];
  endfunction

  // Reference model: stored seed, position in frame, output stage.
  logic       m_valid = 1'b0, m_bit = 1'b0, m_last = 1'b0;
  logic [7:0] m_seed = SEED;
  int         m_idx = 0;
  logic       obs_bit[$], obs_last[$], sent[$];
  int         got = 0;

  always @(negedge clk) begin
    logic m_rdy, xfer, d;
    m_rdy = (!m_valid || a.out_ready) && !tb_seed_load;
    chk("in_ready",  a.in_ready,  m_rdy);
    chk("out_valid", a.out_valid, m_valid);
    chk("out_bit",   a.out_bit,   m_bit);
    chk("out_last",  a.out_last,  m_last);
    if (a.out_valid && a.out_ready) begin
      obs_bit.push_back(a.out_bit);
      obs_last.push_back(a.out_last);
    end
    if (lb && !rst) begin
      if (tb_in_valid && a.in_ready) sent.push_back(tb_in_bit);
      if (b.out_valid && b.out_ready) begin
        got++;
        if (sent.size() == 0) chk("loopback_extra", 1, 0);
        else begin
          d = sent.pop_front();
          chk("loopback", b.out_bit, d);
        end
      end
    end
    if (rst) begin
      m_valid = 0; m_bit = 0; m_last = 0; m_seed = SEED; m_idx = 0;
    end else begin
      xfer = tb_in_valid && m_rdy;
      if (tb_seed_load) begin
        m_seed = (tb_seed == 0) ? 8'h01 : tb_seed;
        m_idx  = 0;
      end
      if (xfer) begin
        m_bit   = tb_in_bit ^ keybit(m_seed, m_idx);
        m_last  = (m_idx == FL - 1);
        m_valid = 1;
        m_idx   = (m_idx + 1) % FL;
      end else if (m_valid && a.out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  // Offer one bit and hold it until it is accepted.
  task automatic send(logic bv);
    tb_in_valid = 1; tb_in_bit = bv;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (a.in_ready) begin
        tick();
        tb_in_valid = 0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    tb_in_valid = 0;
  endtask

  logic [7:0]  exp_ks;
  logic [63:0] data;
  int          idx;

  initial begin
    exp_ks = 8'h71;  // key bits 1,0,0,0,1,1,1,0 for seed 01, LSB first
    idle(2);
    rst = 0;
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_last", a.out_last, 0);
    for (int i = 0; i < 8; i++) chk("model_keystream", keybit(SEED, i), exp_ks[i]);

    // keystream from reset seed
    obs_bit.delete(); obs_last.delete();
    repeat (8) send(0);
    idle(3);
    chk("ks_count", obs_bit.size(), 8);
    for (int i = 0; i < 8 && i < obs_bit.size(); i++) chk("ks_bit", obs_bit[i], exp_ks[i]);

    // frame restart
    do_reset();
    obs_bit.delete(); obs_last.delete();
    repeat (24) send(0);
    idle(3);
    chk("frame_count", obs_bit.size(), 24);
    for (int i = 0; i < 24 && i < obs_bit.size(); i++) begin
      chk("frame_last", obs_last[i], (i == 15));
      if (i >= 16) chk("frame_restart_bit", obs_bit[i], exp_ks[i-16]);
    end

    // backpressure
    do_reset();
    obs_bit.delete(); obs_last.delete();
    send(0);
    tb_out_ready = 0; tb_in_valid = 1; tb_in_bit = 1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", a.in_ready, 0);
      chk("stall_out_bit", a.out_bit, 1);
      tick();
    end
    tb_in_valid = 0; tb_out_ready = 1;
    repeat (7) send(0);
    idle(3);
    chk("bp_count", obs_bit.size(), 8);
    for (int i = 0; i < 8 && i < obs_bit.size(); i++) chk("bp_bit", obs_bit[i], exp_ks[i]);

    // loopback scrambler -> descrambler, both seeded 5A
    do_reset();
    lb = 1; got = 0; sent.delete();
    tb_seed = 8'h5A; tb_seed_load = 1; tb_b_seed_load = 1;
    tick();
    tb_seed_load = 0; tb_b_seed_load = 0;
    data = {$urandom(), $urandom()};
    idx = 0;
    for (int cyc = 0; cyc < 2000 && got < 64; cyc++) begin
      tb_b_ready  = ($urandom_range(0, 3) != 0);
      tb_in_valid = (idx < 64) && ($urandom_range(0, 3) != 0);
      tb_in_bit   = data[idx[5:0]];
      @(negedge clk);
      if (tb_in_valid && a.in_ready) idx++;
      tick();
    end
    tb_in_valid = 0;
    chk("loopback_count", got, 64);
    chk("loopback_leftover", sent.size(), 0);
    lb = 0; tb_b_ready = 1;
    idle(2);

    // zero seed loaded mid-frame with a pending output
    do_reset();
    obs_bit.delete(); obs_last.delete();
    repeat (3) send(0);
    tb_out_ready = 0; tb_seed = 8'h00; tb_seed_load = 1; tb_in_valid = 1;
    @(negedge clk);
    chk("load_in_ready", a.in_ready, 0);
    tick();
    tb_seed_load = 0; tb_in_valid = 0; tb_out_ready = 1;
    repeat (16) send(0);
    idle(3);
    chk("load_count", obs_bit.size(), 19);
    if (obs_bit.size() == 19) begin
      chk("load_pending_bit", obs_bit[2], exp_ks[2]);
      for (int i = 3; i < 11; i++) chk("load_key_bit", obs_bit[i], exp_ks[i-3]);
      for (int i = 3; i < 19; i++) chk("load_last", obs_last[i], (i == 18));
    end

    // reset mid-frame
    do_reset();
    repeat (5) send(0);
    tb_out_ready = 0;
    rst = 1; tick(); rst = 0;
    chk("midrst_out_valid", a.out_valid, 0);
    chk("midrst_out_last", a.out_last, 0);
    tb_out_ready = 1;
    obs_bit.delete(); obs_last.delete();
    repeat (8) send(0);
    idle(3);
    chk("midrst_count", obs_bit.size(), 8);
    for (int i = 0; i < 8 && i < obs_bit.size(); i++) chk("midrst_bit", obs_bit[i], exp_ks[i]);

    // random traffic with occasional seed loads (zero seeds included)
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      tb_in_valid  = $urandom_range(0, 3) != 0;
      tb_in_bit    = $urandom_range(0, 1) != 0;
      tb_out_ready = $urandom_range(0, 3) != 0;
      tb_seed_load = $urandom_range(0, 40) == 0;
      tb_seed      = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom());
      tick();
    end
    tb_in_valid = 0; tb_seed_load = 0; tb_out_ready = 1;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
